// File: rtl/btree_search_controller_pkg.sv
// Shared types and widths for the B-tree search controller.
// Node-index bank signals are sized from these constants.
package btree_search_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int KEY_W  = 4;
  localparam int DATA_W = 4;
  localparam int NODE_W = 8;
  localparam int ADDR_W = 16;

  localparam logic [NODE_W-1:0] NULL_NODE = '0;

endpackage

// File: rtl/btree_search_controller.sv
// Walks an external combinational node-index bank from the root,
// one node per cycle, until a hit, a leaf, or the level limit.
module btree_search_controller
  import btree_search_controller_pkg::*;
#(
  parameter int pRootAddress = 1,
  parameter int pMaxLevels   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [DATA_W-1:0] data,
  output logic              overflow,
  output logic [3:0]        levels,
  output logic [KEY_W-1:0]  idxKey,
  output logic [ADDR_W-1:0] idxAddress,
  input  logic              idxFound,
  input  logic [DATA_W-1:0] idxData,
  input  logic [NODE_W-1:0] idxNode
);

  localparam logic [ADDR_W-1:0] ROOT = ADDR_W'(pRootAddress);
  localparam logic [3:0]        MAXL = 4'(pMaxLevels);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [KEY_W-1:0]  key_q, key_n;
  logic              found_q, found_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              ovf_q, ovf_n;
  logic [3:0]        lvl_q, lvl_n;
  logic [3:0]        lvl_inc;

  assign lvl_inc = lvl_q + 4'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      key_q   <= '0;
      found_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      lvl_q   <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      key_q   <= key_n;
      found_q <= found_n;
      data_q  <= data_n;
      ovf_q   <= ovf_n;
      lvl_q   <= lvl_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    key_n   = key_q;
    found_n = found_q;
    data_n  = data_q;
    ovf_n   = ovf_q;
    lvl_n   = lvl_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WALK;
          addr_n  = ROOT;
          key_n   = key;
          found_n = 1'b0;
          data_n  = '0;
          ovf_n   = 1'b0;
          lvl_n   = '0;
        end
      end
      WALK: begin
        lvl_n = (lvl_q == MAXL) ? MAXL : lvl_inc;
        // Address is parked at zero whenever the walk ends.
        if (idxFound) begin
          found_n = 1'b1;
          data_n  = idxData;
          addr_n  = '0;
          state_n = DONE;
        end else if (idxNode == NULL_NODE) begin
          found_n = 1'b0;
          addr_n  = '0;
          state_n = DONE;
        end else if (lvl_inc == MAXL) begin
          ovf_n   = 1'b1;
          addr_n  = '0;
          state_n = DONE;
        end else begin
          addr_n  = {8'h00, idxNode};
        end
      end
      DONE: begin
        addr_n  = '0;
        state_n = IDLE;
      end
      default: begin
        addr_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy       = (state == WALK);
  assign done       = (state == DONE);
  assign found      = found_q;
  assign data       = data_q;
  assign overflow   = ovf_q;
  assign levels     = lvl_q;
  assign idxKey     = key_q;
  assign idxAddress = addr_q;

endmodule
